// File: rtl/ctrled_tick_gen.sv
// Run-controlled periodic tick generator with burst mode and a shadowed period register.
// Optional macro TICK_TOGGLE_CTRL_EN: start/stop pulses toggle between RUN and IDLE (legacy control).
module ctrled_tick_gen #(
    parameter int CNT_W    = 24,
    parameter int CNT_MAX  = 10000000,
    parameter int BURST_W  = 8,
    parameter int INIT_RUN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               period_ld,
    input  logic [CNT_W-1:0]   period_in,
    output logic               update,
    output logic               running,
    output logic               done,
    output logic [BURST_W-1:0] tick_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam state_t             RST_STATE = (INIT_RUN != 0) ? S_RUN : S_IDLE;
    localparam logic [CNT_W-1:0]   P_RST     = CNT_W'(CNT_MAX);
    localparam logic [BURST_W-1:0] TICK_MAX  = '1;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_count, w_count_next;
    logic [CNT_W-1:0]   r_period, w_period_next;
    logic [CNT_W-1:0]   r_shadow, w_shadow_next;
    logic               r_pend, w_pend_next;
    logic               r_mode, w_mode_next;
    logic [BURST_W-1:0] r_blen, w_blen_next;
    logic [BURST_W-1:0] r_tick, w_tick_next;
    logic               r_update, w_update_next;
    logic               r_done, w_done_next;
    logic               r_running, w_running_next;

    logic               w_stop_acc;
    logic               w_start_acc;
    logic               w_mode_in;
    logic [CNT_W-1:0]   w_pe;
    logic               w_wrap;
    logic [BURST_W-1:0] w_tick_inc;
    logic               w_direct_ld;

`ifdef TICK_TOGGLE_CTRL_EN
    logic w_toggle;
    assign w_toggle    = start | stop;
    assign w_stop_acc  = w_toggle && (r_state == S_RUN);
    assign w_start_acc = w_toggle && (r_state != S_RUN);
    assign w_mode_in   = mode & 1'b0;
`else
    assign w_stop_acc  = stop;
    assign w_start_acc = start && !stop;
    assign w_mode_in   = mode;
`endif

    // A zero period behaves as one, so count never needs to reach an unreachable terminal value.
    assign w_pe        = (r_period == '0) ? CNT_W'(1) : r_period;
    assign w_wrap      = (r_state == S_RUN) && (r_count == w_pe - 1'b1);
    assign w_tick_inc  = (r_tick == TICK_MAX) ? r_tick : r_tick + 1'b1;
    assign w_direct_ld = period_ld && ((r_state != S_RUN) || w_stop_acc || w_start_acc);

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_mode_next   = r_mode;
        w_blen_next   = r_blen;
        w_tick_next   = r_tick;
        w_update_next = 1'b0;
        w_done_next   = 1'b0;

        if (w_stop_acc) begin
            w_state_next = S_IDLE;
            w_count_next = '0;
        end else if (w_start_acc) begin
            w_state_next = S_RUN;
            w_count_next = '0;
            w_tick_next  = '0;
            w_mode_next  = w_mode_in;
            w_blen_next  = (burst_len == '0) ? BURST_W'(1) : burst_len;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_wrap) begin
                        w_count_next  = '0;
                        w_update_next = 1'b1;
                        w_tick_next   = w_tick_inc;
                        if (r_mode && (w_tick_inc == r_blen)) begin
                            w_state_next = S_DONE;
                            w_done_next  = 1'b1;
                        end
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_count_next = '0;
            endcase
        end
        w_running_next = (w_state_next == S_RUN);
    end

    // Loads while counting are parked in the shadow and only land when a period ends.
    always_comb begin
        w_period_next = r_period;
        w_shadow_next = r_shadow;
        w_pend_next   = r_pend;
        if (w_direct_ld) begin
            w_period_next = period_in;
            w_shadow_next = period_in;
            w_pend_next   = 1'b0;
        end else begin
            if (r_pend && (w_wrap || w_stop_acc || w_start_acc)) begin
                w_period_next = r_shadow;
                w_pend_next   = 1'b0;
            end
            if (period_ld) begin
                w_shadow_next = period_in;
                w_pend_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RST_STATE;
            r_count   <= '0;
            r_period  <= P_RST;
            r_shadow  <= P_RST;
            r_pend    <= 1'b0;
            r_mode    <= 1'b0;
            r_blen    <= BURST_W'(1);
            r_tick    <= '0;
            r_update  <= 1'b0;
            r_done    <= 1'b0;
            r_running <= (RST_STATE == S_RUN);
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_period  <= w_period_next;
            r_shadow  <= w_shadow_next;
            r_pend    <= w_pend_next;
            r_mode    <= w_mode_next;
            r_blen    <= w_blen_next;
            r_tick    <= w_tick_next;
            r_update  <= w_update_next;
            r_done    <= w_done_next;
            r_running <= w_running_next;
        end
    end

    assign update   = r_update;
    assign running  = r_running;
    assign done     = r_done;
    assign tick_cnt = r_tick;

endmodule
